seq1_chk: RTL and testbench

Serial pattern checker that sits directly downstream of the 3-bit ripple-counter sequence generator. It consumes the generator's single-bit output `f` and aligns to the 8-bit periodic pattern 1,0,0,1,1,0,0,0. It then reports lock status, per-bit mismatch pulses and a saturating error count. It is the self-check stage for the generator in bring-up and BIST use.

---
 rtl/seq1_chk.sv | 170 +++++++++++++++++
 tb/tb_seq1_chk.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq1_chk.sv
// Serial pattern checker for the 3-bit sequence generator output.
// Aligns to an 8-bit periodic pattern, then reports lock, per-bit error pulses and a saturating error count.
module seq1_chk #(
  parameter logic [7:0]  PATTERN      = 8'b1001_1000,
  parameter int unsigned LOCK_PERIODS = 2,
  parameter int unsigned LOSS_RUN     = 3,
  parameter int unsigned ERR_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_vld,
  input  logic             clr_cnt,
  output logic             lock,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt,
  output logic [2:0]       phase
);

  localparam int unsigned HIST_W  = 7;
  localparam int unsigned PHASE_W = 3;
  localparam int unsigned RUN_W   = 4;

  localparam logic [RUN_W-1:0]   LOCK_P    = RUN_W'(LOCK_PERIODS);
  localparam logic [RUN_W-1:0]   LOSS_P    = RUN_W'(LOSS_RUN);
  localparam logic [PHASE_W-1:0] FILL_FULL = PHASE_W'(HIST_W);
  localparam logic [PHASE_W-1:0] PH_LAST   = PHASE_W'(7);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [HIST_W-1:0]  hist_q, hist_d;
  logic [PHASE_W-1:0] fill_q, fill_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [RUN_W-1:0]   period_q, period_d;
  logic [RUN_W-1:0]   miss_q, miss_d;
  logic               lock_q, lock_d;
  logic               err_q, err_d;
  logic [ERR_W-1:0]   cnt_q, cnt_d;

  logic [PHASE_W-1:0] pat_idx;
  logic               exp_bit;
  logic               bit_miss;
  logic [ERR_W-1:0]   cnt_inc;
  logic [RUN_W-1:0]   period_nxt;
  logic [RUN_W-1:0]   miss_nxt;

  // Next-state and output computation; outputs are captured in registers below.
  always_comb begin
    state_d  = state_q;
    hist_d   = hist_q;
    fill_d   = fill_q;
    phase_d  = phase_q;
    period_d = period_q;
    miss_d   = miss_q;
    lock_d   = lock_q;
    err_d    = 1'b0;
    cnt_d    = cnt_q;

    pat_idx    = PH_LAST - phase_q;
    exp_bit    = PATTERN[pat_idx];
    bit_miss   = (din != exp_bit);
    cnt_inc    = (cnt_q == {ERR_W{1'b1}}) ? cnt_q : cnt_q + ERR_W'(1);
    period_nxt = period_q + RUN_W'(1);
    miss_nxt   = miss_q + RUN_W'(1);

    if (din_vld) begin
      unique case (state_q)
        HUNT: begin
          hist_d = {hist_q[HIST_W-2:0], din};
          fill_d = (fill_q == FILL_FULL) ? fill_q : fill_q + PHASE_W'(1);
          if ((fill_q == FILL_FULL) && ({hist_q, din} == PATTERN)) begin
            state_d  = VERIFY;
            phase_d  = '0;
            period_d = '0;
          end
        end

        VERIFY: begin
          phase_d = phase_q + PHASE_W'(1);
          if (bit_miss) begin
            // Alignment was false; restart the search from an empty window.
            state_d  = HUNT;
            hist_d   = '0;
            fill_d   = '0;
            period_d = '0;
            phase_d  = '0;
            miss_d   = '0;
          end else if (phase_q == PH_LAST) begin
            period_d = period_nxt;
            if (period_nxt == LOCK_P) begin
              state_d = LOCKED;
              lock_d  = 1'b1;
              miss_d  = '0;
            end
          end
        end

        LOCKED: begin
          phase_d = phase_q + PHASE_W'(1);
          if (bit_miss) begin
            err_d  = 1'b1;
            cnt_d  = cnt_inc;
            miss_d = miss_nxt;
            if (miss_nxt == LOSS_P) begin
              state_d  = HUNT;
              lock_d   = 1'b0;
              hist_d   = '0;
              fill_d   = '0;
              period_d = '0;
              phase_d  = '0;
              miss_d   = '0;
            end
          end else begin
            miss_d = '0;
          end
        end

        default: begin
          state_d  = HUNT;
          lock_d   = 1'b0;
          hist_d   = '0;
          fill_d   = '0;
          period_d = '0;
          phase_d  = '0;
          miss_d   = '0;
        end
      endcase
    end

    // Clear has priority over a same-edge increment.
    if (clr_cnt) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= HUNT;
      hist_q   <= '0;
      fill_q   <= '0;
      phase_q  <= '0;
      period_q <= '0;
      miss_q   <= '0;
      lock_q   <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      hist_q   <= hist_d;
      fill_q   <= fill_d;
      phase_q  <= phase_d;
      period_q <= period_d;
      miss_q   <= miss_d;
      lock_q   <= lock_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign lock    = lock_q;
  assign err     = err_q;
  assign err_cnt = cnt_q;
  assign phase   = phase_q;

endmodule

// File: tb/tb_seq1_chk.sv
// Bench for seq1_chk: scenario tasks push expected outputs per edge, a monitor pops and compares.
`timescale 1ns/1ps
module tb_seq1_chk;

  localparam logic [7:0] PAT = 8'b1001_1000;

  typedef struct packed {
    logic       lock;
    logic       err;
    logic [7:0] cnt;
    logic [2:0] phase;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       din = 1'b0;
  logic       din_vld = 1'b0;
  logic       clr_cnt = 1'b0;
  logic       lock;
  logic       err;
  logic [7:0] err_cnt;
  logic [2:0] phase;

  exp_t  exp_q[$];
  exp_t  last_exp;
  exp_t  mon_e;
  int    n_vec = 0;
  int    n_bad = 0;
  int    gpos = 0;
  int    cur_cnt = 0;
  string tag = "init";

  always #5 clk = ~clk;

  seq1_chk dut (
    .clk     (clk),
    .rst     (rst),
    .din     (din),
    .din_vld (din_vld),
    .clr_cnt (clr_cnt),
    .lock    (lock),
    .err     (err),
    .err_cnt (err_cnt),
    .phase   (phase)
  );

  // Scoreboard: one expectation per driven edge, compared just after that edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      n_vec++;
      if ({lock, err, err_cnt, phase} !== mon_e) begin
        n_bad++;
        $display("FAIL %s @%0t: got lock=%0b err=%0b cnt=%0d phase=%0d, want lock=%0b err=%0b cnt=%0d phase=%0d",
                 tag, $time, lock, err, err_cnt, phase,
                 mon_e.lock, mon_e.err, mon_e.cnt, mon_e.phase);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic pat_bit(input int g);
    logic [7:0] p;
    p = PAT;
    return p[7-g];
  endfunction

  task automatic drive(input logic d, input logic v, input logic c, input exp_t e);
    @(negedge clk);
    din     = d;
    din_vld = v;
    clr_cnt = c;
    exp_q.push_back(e);
    last_exp = e;
    @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst     = 1'b0;
    din     = 1'b0;
    din_vld = 1'b0;
    clr_cnt = 1'b0;
    @(negedge clk);
    rst      = 1'b1;
    gpos     = 0;
    cur_cnt  = 0;
    last_exp = '0;
  endtask

  // Clean generator stream starting in HUNT with an empty window.
  task automatic feed_hunt(input int n, input bit toggle);
    int   k0;
    exp_t e;
    logic b;
    k0 = ((8 - gpos) % 8) + 1;
    for (int k = 1; k <= n; k++) begin
      if (toggle) begin
        e     = last_exp;
        e.err = 1'b0;
        drive(~pat_bit(gpos), 1'b0, 1'b0, e);
      end
      b       = pat_bit(gpos);
      gpos    = (gpos + 1) % 8;
      e.lock  = (k >= k0 + 23);
      e.err   = 1'b0;
      e.cnt   = 8'(cur_cnt);
      e.phase = (k >= k0 + 7) ? 3'(gpos) : 3'd0;
      drive(b, 1'b1, 1'b0, e);
    end
  endtask

  task automatic feed_locked(input int n);
    exp_t e;
    logic b;
    for (int k = 0; k < n; k++) begin
      b       = pat_bit(gpos);
      gpos    = (gpos + 1) % 8;
      e.lock  = 1'b1;
      e.err   = 1'b0;
      e.cnt   = 8'(cur_cnt);
      e.phase = 3'(gpos);
      drive(b, 1'b1, 1'b0, e);
    end
  endtask

  task automatic inject(input bit clr, input bit in_lock, input bit lock_after);
    exp_t e;
    logic b;
    b    = ~pat_bit(gpos);
    gpos = (gpos + 1) % 8;
    if (in_lock) begin
      cur_cnt = clr ? 0 : ((cur_cnt == 255) ? 255 : cur_cnt + 1);
      e.lock  = lock_after;
      e.err   = 1'b1;
      e.cnt   = 8'(cur_cnt);
      e.phase = lock_after ? 3'(gpos) : 3'd0;
    end else begin
      cur_cnt = clr ? 0 : cur_cnt;
      e.lock  = 1'b0;
      e.err   = 1'b0;
      e.cnt   = 8'(cur_cnt);
      e.phase = 3'd0;
    end
    drive(b, 1'b1, clr, e);
  endtask

  task automatic test_reset();
    tag = "reset";
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({lock, err, err_cnt, phase} !== 13'd0) begin
      n_bad++;
      $display("FAIL reset: got lock=%0b err=%0b cnt=%0d phase=%0d, want all 0", lock, err, err_cnt, phase);
    end
  endtask

  task automatic test_aligned();
    tag = "aligned";
    do_reset();
    feed_hunt(32, 1'b0);
  endtask

  task automatic test_offset();
    tag = "offset3";
    do_reset();
    gpos = 3;
    feed_hunt(32, 1'b0);
  endtask

  task automatic test_verify_miss();
    tag = "verify_miss";
    do_reset();
    feed_hunt(10, 1'b0);
    inject(1'b0, 1'b0, 1'b0);
    feed_hunt(32, 1'b0);
  endtask

  task automatic test_single_err();
    tag = "single_err";
    do_reset();
    feed_hunt(32, 1'b0);
    inject(1'b0, 1'b1, 1'b1);
    feed_locked(8);
  endtask

  task automatic test_loss();
    tag = "loss";
    do_reset();
    feed_hunt(32, 1'b0);
    feed_locked(3);
    inject(1'b0, 1'b1, 1'b1);
    inject(1'b0, 1'b1, 1'b1);
    inject(1'b0, 1'b1, 1'b0);
    tag = "relock";
    feed_hunt(32, 1'b0);
  endtask

  task automatic test_valid_toggle();
    tag = "vld_toggle";
    do_reset();
    feed_hunt(32, 1'b1);
  endtask

  task automatic test_clr_cnt();
    exp_t e;
    tag = "clr_cnt";
    do_reset();
    feed_hunt(32, 1'b0);
    repeat (5) begin
      inject(1'b0, 1'b1, 1'b1);
      feed_locked(1);
    end
    inject(1'b1, 1'b1, 1'b1);
    feed_locked(2);
    tag = "saturate";
    repeat (260) begin
      inject(1'b0, 1'b1, 1'b1);
      feed_locked(1);
    end
    tag = "clr_invalid";
    cur_cnt = 0;
    e       = last_exp;
    e.err   = 1'b0;
    e.cnt   = 8'd0;
    drive(~pat_bit(gpos), 1'b0, 1'b1, e);
    feed_locked(4);
  endtask

  task automatic test_async_reset();
    tag = "async_reset";
    do_reset();
    feed_hunt(32, 1'b0);
    inject(1'b0, 1'b1, 1'b1);
    feed_locked(2);
    @(negedge clk);
    din_vld = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    n_vec++;
    if ({lock, err, err_cnt, phase} !== 13'd0) begin
      n_bad++;
      $display("FAIL async_reset: got lock=%0b err=%0b cnt=%0d phase=%0d, want all 0 before edge",
               lock, err, err_cnt, phase);
    end
    @(posedge clk);
    #1;
    n_vec++;
    if ({lock, err, err_cnt, phase} !== 13'd0) begin
      n_bad++;
      $display("FAIL async_reset_hold: got lock=%0b err=%0b cnt=%0d phase=%0d, want all 0",
               lock, err, err_cnt, phase);
    end
    @(negedge clk);
    rst      = 1'b1;
    gpos     = 0;
    cur_cnt  = 0;
    last_exp = '0;
    tag = "post_reset";
    feed_hunt(32, 1'b0);
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_offset();
    test_verify_miss();
    test_single_err();
    test_loss();
    test_valid_toggle();
    test_clr_cnt();
    test_async_reset();
    @(negedge clk);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
